// File: rtl/adxl362_pkg.sv
// Shared constants for the ADXL362 SPI register responder: commands, register
// addresses, soft-reset key and the transaction FSM encoding.
package adxl362_pkg;

  localparam logic [7:0] CMD_WRITE      = 8'h0A;
  localparam logic [7:0] CMD_READ       = 8'h0B;
  localparam logic [7:0] SOFT_RESET_KEY = 8'h52;

  localparam logic [7:0] ADDR_DEVID_AD  = 8'h00;
  localparam logic [7:0] ADDR_DEVID_MST = 8'h01;
  localparam logic [7:0] ADDR_PARTID    = 8'h02;
  localparam logic [7:0] ADDR_XDATA     = 8'h08;
  localparam logic [7:0] ADDR_YDATA     = 8'h09;
  localparam logic [7:0] ADDR_ZDATA     = 8'h0A;
  localparam logic [7:0] ADDR_STATUS    = 8'h0B;
  localparam logic [7:0] ADDR_XDATA_L   = 8'h0E;
  localparam logic [7:0] ADDR_XDATA_H   = 8'h0F;
  localparam logic [7:0] ADDR_YDATA_L   = 8'h10;
  localparam logic [7:0] ADDR_YDATA_H   = 8'h11;
  localparam logic [7:0] ADDR_ZDATA_L   = 8'h12;
  localparam logic [7:0] ADDR_ZDATA_H   = 8'h13;
  localparam logic [7:0] ADDR_SOFT_RST  = 8'h1F;
  localparam logic [7:0] ADDR_POWER_CTL = 8'h2D;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_RDATA,
    ST_WDATA,
    ST_SKIP
  } spi_state_t;

  // High byte of a 12-bit sample, sign-extended into the upper nibble.
  function automatic logic [7:0] sample_hi(input logic [11:0] v);
    return {{4{v[11]}}, v[11:8]};
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizer for one asynchronous SPI pin followed by a one-flop
// edge detector; rise/fall are single-cycle strobes in the clk_50 domain.
module spi_pin_sync (
  input  logic clk_50,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync1_q, sync2_q, delay_q;

  // Reset to 0 so a chip select already low at reset release yields no fall.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      delay_q <= 1'b0;
    end else begin
      sync1_q <= pin;
      sync2_q <= sync1_q;
      delay_q <= sync2_q;
    end
  end

  assign level = sync2_q;
  assign rise  = sync2_q & ~delay_q;
  assign fall  = ~sync2_q & delay_q;

endmodule

// File: rtl/adxl362_spi_responder.sv
// SPI mode-0 slave emulating the ADXL362 register interface: ID, status,
// coherent X/Y/Z sample snapshot and a writable POWER_CTL register.
module adxl362_spi_responder
  import adxl362_pkg::*;
#(
  parameter logic [7:0] DEVID_AD  = 8'hAD,
  parameter logic [7:0] DEVID_MST = 8'h1D,
  parameter logic [7:0] PARTID    = 8'hF2
) (
  input  logic        clk_50,
  input  logic        reset,
  input  logic        SCLK,
  input  logic        MOSI,
  input  logic        n_CS,
  output logic        MISO,
  input  logic [11:0] x_acc_in,
  input  logic [11:0] y_acc_in,
  input  logic [11:0] z_acc_in,
  input  logic        data_ready,
  output logic [7:0]  power_ctl,
  output logic        busy
);

  logic sclk_level, sclk_rise, sclk_fall;
  logic mosi_level, mosi_rise, mosi_fall;
  logic cs_level, cs_rise, cs_fall;
  logic unused_sync;

  spi_pin_sync u_sync_sclk (.clk_50(clk_50), .reset(reset), .pin(SCLK),
                            .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall));
  spi_pin_sync u_sync_mosi (.clk_50(clk_50), .reset(reset), .pin(MOSI),
                            .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall));
  spi_pin_sync u_sync_cs   (.clk_50(clk_50), .reset(reset), .pin(n_CS),
                            .level(cs_level), .rise(cs_rise), .fall(cs_fall));

  assign unused_sync = ^{sclk_level, mosi_rise, mosi_fall};

  spi_state_t  state_q, state_next;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  rx_shift_q, tx_shift_q, addr_q, power_ctl_q;
  logic        is_read_q, miso_q, dr_q;
  logic [11:0] shadow_x_q, shadow_y_q, shadow_z_q;

  logic [7:0]  rx_byte, reg_rdata;
  logic        byte_done, tx_load, wr_en, soft_clear, dr_clear;

  // Per-cycle events derived from the synchronized strobes.
  always_comb begin
    rx_byte    = {rx_shift_q[6:0], mosi_level};
    byte_done  = 1'b0;
    tx_load    = 1'b0;
    wr_en      = 1'b0;
    soft_clear = 1'b0;
    dr_clear   = 1'b0;
    if (sclk_rise && bit_cnt_q == 3'd7)
      byte_done = 1'b1;
    if (state_q == ST_RDATA && sclk_fall && bit_cnt_q == 3'd0)
      tx_load = 1'b1;
    if (state_q == ST_WDATA && byte_done)
      wr_en = 1'b1;
    if (wr_en && addr_q == ADDR_SOFT_RST && rx_byte == SOFT_RESET_KEY)
      soft_clear = 1'b1;
    if (tx_load && (addr_q == ADDR_XDATA_L || addr_q == ADDR_XDATA))
      dr_clear = 1'b1;
    if (soft_clear)
      dr_clear = 1'b1;
  end

  always_comb begin
    reg_rdata = 8'h00;
    case (addr_q)
      ADDR_DEVID_AD:  reg_rdata = DEVID_AD;
      ADDR_DEVID_MST: reg_rdata = DEVID_MST;
      ADDR_PARTID:    reg_rdata = PARTID;
      ADDR_XDATA:     reg_rdata = shadow_x_q[11:4];
      ADDR_YDATA:     reg_rdata = shadow_y_q[11:4];
      ADDR_ZDATA:     reg_rdata = shadow_z_q[11:4];
      ADDR_STATUS:    reg_rdata = {7'b0, dr_q};
      ADDR_XDATA_L:   reg_rdata = shadow_x_q[7:0];
      ADDR_XDATA_H:   reg_rdata = sample_hi(shadow_x_q);
      ADDR_YDATA_L:   reg_rdata = shadow_y_q[7:0];
      ADDR_YDATA_H:   reg_rdata = sample_hi(shadow_y_q);
      ADDR_ZDATA_L:   reg_rdata = shadow_z_q[7:0];
      ADDR_ZDATA_H:   reg_rdata = sample_hi(shadow_z_q);
      ADDR_POWER_CTL: reg_rdata = power_ctl_q;
      default:        reg_rdata = 8'h00;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_next;
  end

  // FSM: next state; a high chip select always returns to IDLE.
  always_comb begin
    state_next = state_q;
    if (cs_level || cs_rise) begin
      state_next = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (cs_fall) state_next = ST_CMD;
        ST_CMD:
          if (byte_done)
            state_next = (rx_byte == CMD_READ || rx_byte == CMD_WRITE) ? ST_ADDR : ST_SKIP;
        ST_ADDR:
          if (byte_done)
            state_next = is_read_q ? ST_RDATA : ST_WDATA;
        default: state_next = state_q;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    busy      = (state_q != ST_IDLE);
    MISO      = miso_q;
    power_ctl = power_ctl_q;
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 8'h00;
      tx_shift_q  <= 8'h00;
      addr_q      <= 8'h00;
      is_read_q   <= 1'b0;
      miso_q      <= 1'b0;
      power_ctl_q <= 8'h00;
      dr_q        <= 1'b0;
      shadow_x_q  <= 12'h000;
      shadow_y_q  <= 12'h000;
      shadow_z_q  <= 12'h000;
    end else begin
      if (cs_fall) begin
        shadow_x_q <= x_acc_in;
        shadow_y_q <= y_acc_in;
        shadow_z_q <= z_acc_in;
      end

      if (state_q == ST_IDLE)
        bit_cnt_q <= 3'd0;
      else if (sclk_rise && state_q != ST_SKIP)
        bit_cnt_q <= bit_cnt_q + 3'd1;

      if (sclk_rise)
        rx_shift_q <= rx_byte;

      if (state_q == ST_CMD && byte_done)
        is_read_q <= (rx_byte == CMD_READ);

      if (state_q == ST_ADDR && byte_done)
        addr_q <= rx_byte;
      else if ((state_q == ST_RDATA || state_q == ST_WDATA) && byte_done)
        addr_q <= addr_q + 8'd1;

      if (tx_load)
        tx_shift_q <= reg_rdata;
      else if (state_q == ST_RDATA && sclk_fall)
        tx_shift_q <= {tx_shift_q[6:0], 1'b0};

      if (state_next != ST_RDATA)
        miso_q <= 1'b0;
      else if (tx_load)
        miso_q <= reg_rdata[7];
      else if (sclk_fall)
        miso_q <= tx_shift_q[6];

      if (wr_en && addr_q == ADDR_POWER_CTL)
        power_ctl_q <= rx_byte;
      else if (soft_clear)
        power_ctl_q <= 8'h00;

      // A new sample pulse takes priority over any clearing event.
      if (data_ready)
        dr_q <= 1'b1;
      else if (dr_clear)
        dr_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adxl362_spi_responder.sv
// Directed plus randomized bench for adxl362_spi_responder, checked against a
// register-map reference model that tracks the snapshot, status and POWER_CTL.
module tb_adxl362_spi_responder;

  localparam int HALF = 8;

  logic        clk_50 = 1'b0;
  logic        reset, SCLK, MOSI, n_CS, MISO, data_ready, busy;
  logic [11:0] x_acc_in, y_acc_in, z_acc_in;
  logic [7:0]  power_ctl;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [11:0] m_x = 12'h0, m_y = 12'h0, m_z = 12'h0;
  logic [7:0]  m_pwr = 8'h00;
  logic        m_dr = 1'b0;

  adxl362_spi_responder dut (
    .clk_50(clk_50), .reset(reset), .SCLK(SCLK), .MOSI(MOSI), .n_CS(n_CS),
    .MISO(MISO), .x_acc_in(x_acc_in), .y_acc_in(y_acc_in), .z_acc_in(z_acc_in),
    .data_ready(data_ready), .power_ctl(power_ctl), .busy(busy)
  );

  always #5 clk_50 = ~clk_50;

  initial begin
    #900000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_reg(input logic [7:0] a);
    case (a)
      8'h00: return 8'hAD;
      8'h01: return 8'h1D;
      8'h02: return 8'hF2;
      8'h08: return m_x[11:4];
      8'h09: return m_y[11:4];
      8'h0A: return m_z[11:4];
      8'h0B: return {7'b0, m_dr};
      8'h0E: return m_x[7:0];
      8'h0F: return {{4{m_x[11]}}, m_x[11:8]};
      8'h10: return m_y[7:0];
      8'h11: return {{4{m_y[11]}}, m_y[11:8]};
      8'h12: return m_z[7:0];
      8'h13: return {{4{m_z[11]}}, m_z[11:8]};
      8'h2D: return m_pwr;
      default: return 8'h00;
    endcase
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk_50);
    #1;
  endtask

  // Shift nbits of tx (MSB first) while capturing MISO before each rising edge.
  task automatic xfer(input logic [7:0] tx, input int nbits, input bit pulse_last,
                      output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      MOSI = tx[i];
      wait_clk(HALF);
      rx[i] = MISO;
      SCLK = 1'b1;
      wait_clk(HALF);
      SCLK = 1'b0;
      if (pulse_last && i == 0) begin
        // land the pulse on the cycle that consumes the fall strobe
        wait_clk(2);
        data_ready = 1'b1;
        wait_clk(1);
        data_ready = 1'b0;
      end
    end
  endtask

  task automatic cs_low();
    wait_clk(2);
    n_CS = 1'b0;
    m_x = x_acc_in; m_y = y_acc_in; m_z = z_acc_in;
    wait_clk(HALF);
  endtask

  task automatic cs_high();
    wait_clk(HALF);
    n_CS = 1'b1;
    wait_clk(HALF);
  endtask

  task automatic pulse_dr();
    wait_clk(1);
    data_ready = 1'b1;
    wait_clk(1);
    data_ready = 1'b0;
    m_dr = 1'b1;
  endtask

  task automatic rand_inputs();
    x_acc_in = 12'($urandom);
    y_acc_in = 12'($urandom);
    z_acc_in = 12'($urandom);
  endtask

  // Burst read of n bytes; every byte boundary loads one more address than read.
  task automatic do_read(input logic [7:0] a, input int n, input string tag, input bit scramble);
    logic [7:0] rx, exp, ak;
    cs_low();
    xfer(8'h0B, 8, 1'b0, rx);
    check({tag, "_busy_cmd"}, busy, 1'b1);
    xfer(a, 8, 1'b0, rx);
    for (int k = 0; k <= n; k++) begin
      ak = a + 8'(k);
      exp = model_reg(ak);
      if (ak == 8'h0E || ak == 8'h08) m_dr = 1'b0;
      if (k < n) begin
        xfer(8'h00, 8, 1'b0, rx);
        check($sformatf("%s_a%02h", tag, ak), rx, exp);
        if (scramble && k == 1) rand_inputs();
      end
    end
    check({tag, "_busy_end"}, busy, 1'b1);
    cs_high();
    check({tag, "_busy_idle"}, busy, 1'b0);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input string tag);
    logic [7:0] rx;
    cs_low();
    xfer(8'h0A, 8, 1'b0, rx);
    xfer(a, 8, 1'b0, rx);
    xfer(d, 8, 1'b0, rx);
    check({tag, "_miso"}, rx, 8'h00);
    cs_high();
    if (a == 8'h2D) m_pwr = d;
    if (a == 8'h1F && d == 8'h52) begin m_pwr = 8'h00; m_dr = 1'b0; end
    check({tag, "_power_ctl"}, power_ctl, m_pwr);
  endtask

  initial begin
    logic [7:0] rx;
    int sel;
    reset = 1'b1; SCLK = 1'b0; MOSI = 1'b0; n_CS = 1'b1; data_ready = 1'b0;
    x_acc_in = 12'h0; y_acc_in = 12'h0; z_acc_in = 12'h0;
    wait_clk(4);
    check("rst_miso", MISO, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_power_ctl", power_ctl, 8'h00);
    reset = 1'b0;
    wait_clk(HALF);

    do_read(8'h00, 3, "ids", 1'b0);

    x_acc_in = 12'h800; y_acc_in = 12'h7FF; z_acc_in = 12'h001;
    do_read(8'h0E, 6, "burst", 1'b1);

    do_write(8'h2D, 8'h02, "wr_pwr");
    do_write(8'h1F, 8'h52, "soft_rst");
    do_write(8'h2D, 8'hA5, "wr_pwr2");
    do_write(8'h1F, 8'h51, "soft_bad");
    do_write(8'h33, 8'hFF, "wr_unmapped");

    pulse_dr();
    do_read(8'h0B, 1, "status_set", 1'b0);
    do_read(8'h0E, 1, "status_rd_x", 1'b0);
    do_read(8'h0B, 1, "status_clr", 1'b0);

    // data_ready coincident with the 0x0E load: set wins
    cs_low();
    xfer(8'h0B, 8, 1'b0, rx);
    xfer(8'h0E, 8, 1'b1, rx);
    cs_high();
    m_dr = 1'b1;
    do_read(8'h0B, 1, "status_coincide", 1'b0);

    // partial write byte is discarded
    cs_low();
    xfer(8'h0A, 8, 1'b0, rx);
    xfer(8'h2D, 8, 1'b0, rx);
    xfer(8'hC3, 4, 1'b0, rx);
    cs_high();
    check("abort_power_ctl", power_ctl, m_pwr);

    // unknown command: MISO held low for two bytes
    cs_low();
    xfer(8'h0D, 8, 1'b0, rx);
    xfer(8'hFF, 8, 1'b0, rx);
    check("skip_miso0", rx, 8'h00);
    xfer(8'hA5, 8, 1'b0, rx);
    check("skip_miso1", rx, 8'h00);
    check("skip_busy", busy, 1'b1);
    cs_high();

    do_read(8'hFF, 2, "wrap", 1'b0);

    for (int it = 0; it < 24; it++) begin
      rand_inputs();
      sel = $urandom_range(0, 4);
      if (sel == 0) begin
        pulse_dr();
      end else if (sel == 1) begin
        case ($urandom_range(0, 2))
          0: do_write(8'h2D, 8'($urandom), "rnd_wr");
          1: do_write(8'h1F, ($urandom_range(0, 1) == 0) ? 8'h52 : 8'($urandom), "rnd_wr");
          default: do_write(8'($urandom), 8'($urandom), "rnd_wr");
        endcase
      end else if (sel == 2) begin
        do_read(8'($urandom_range(8'hF8, 8'hFF)), $urandom_range(1, 4), "rnd_rd", 1'b1);
      end else begin
        do_read(8'($urandom_range(0, 8'h30)), $urandom_range(1, 4), "rnd_rd", 1'b1);
      end
    end

    // reset during a read while MISO is high (0xAD starts with a 1)
    do_write(8'h2D, 8'h33, "pre_rst");
    cs_low();
    xfer(8'h0B, 8, 1'b0, rx);
    xfer(8'h00, 8, 1'b0, rx);
    xfer(8'h00, 2, 1'b0, rx);
    check("pre_rst_miso", rx[7:6], 2'b10);
    #3;
    reset = 1'b1;
    #1;
    check("midrst_miso", MISO, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_power_ctl", power_ctl, 8'h00);
    m_pwr = 8'h00; m_dr = 1'b0;
    wait_clk(2);
    reset = 1'b0;
    SCLK = 1'b0;
    wait_clk(HALF);
    xfer(8'h0B, 8, 1'b0, rx);
    xfer(8'h00, 8, 1'b0, rx);
    check("postrst_busy", busy, 1'b0);
    xfer(8'h00, 8, 1'b0, rx);
    check("postrst_miso", rx, 8'h00);
    cs_high();

    do_read(8'h00, 1, "post_rst_id", 1'b0);
    do_read(8'h0B, 1, "post_rst_status", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adxl362_spi_responder.md
Name: adxl362_spi_responder

Overview:
- Synthesizable SPI mode-0 slave that emulates the ADXL362 register interface.
- Lets the accelerometer SPI master be exercised in simulation and on-board loopback without the physical sensor.
- Oversamples SCLK, MOSI and n_CS in the clk_50 domain, decodes read/write register commands, and serves ID, status and 12-bit X/Y/Z sample registers.
- X/Y/Z values come from input ports, typically a test pattern or a stimulus block.

Parameters:
- DEVID_AD, 8'hAD, value returned at address 0x00
- DEVID_MST, 8'h1D, value returned at address 0x01
- PARTID, 8'hF2, value returned at address 0x02

Ports:
- clk_50  input  1  system clock; the only clock
- reset  input  1  asynchronous, active-high reset
- SCLK  input  1  SPI clock from master, asynchronous to clk_50; frequency at most clk_50/8
- MOSI  input  1  SPI data from master
- n_CS  input  1  SPI chip select, active low
- MISO  output  1  SPI data to master
- x_acc_in, y_acc_in, z_acc_in  input  12  two's-complement sample sources
- data_ready  input  1  single-cycle pulse: new sample available
- power_ctl  output  8  POWER_CTL register (0x2D) contents
- busy  output  1  high while a transaction is active (state != IDLE)

Behaviour:
- Reset values: MISO=0, power_ctl=0, busy=0, status DATA_READY=0, shadow X/Y/Z=0, state=IDLE.
- Input sync: SCLK, MOSI and n_CS each pass through a 2-flop synchronizer, then a 1-flop edge detector.
  - Rise, fall and cs_fall/cs_rise are single-cycle strobes, 3 clk_50 cycles after the pin edge.
  - MISO is registered and updates 1 cycle after the sclk fall strobe.
- Snapshot: on the cs_fall strobe, latch x/y/z_acc_in into shadow registers. All reads within the transaction use the shadow values, so the six data bytes are coherent.
- FSM states: IDLE, CMD, ADDR, RDATA, WDATA, SKIP.
  - IDLE -> CMD on cs_fall; bit counter cleared.
  - CMD: shift MOSI in, MSB first, on each sclk rise. After the 8th bit: 0x0B -> ADDR(read), 0x0A -> ADDR(write), anything else -> SKIP.
  - ADDR: 8 bits shifted in, then the address pointer is loaded. Read goes to RDATA, write goes to WDATA.
  - RDATA: on the first sclk fall after the address byte, load tx_shift = reg[addr] and drive bit 7.
    - Each subsequent fall shifts out the next bit.
    - After the 8th rise of a byte, addr increments; the next fall loads reg[addr].
  - WDATA: after every 8th rise, write the received byte to reg[addr] if writable, then addr increments.
  - SKIP: ignore all edges; MISO=0.
  - Any state -> IDLE on cs_rise or whenever synchronized n_CS is high. A partial byte is discarded and not written. MISO=0.
- MISO is 0 in IDLE, CMD, ADDR, WDATA and SKIP.
- Address pointer is 8 bits and wraps 0xFF -> 0x00. Unmapped addresses read 0x00.
- Register map:
  - 0x00/0x01/0x02: ID parameters.
  - 0x08/0x09/0x0A: shadow X/Y/Z bits [11:4].
  - 0x0B: STATUS, {7'b0, DATA_READY}.
  - 0x0E/0x0F: XDATA_L = x[7:0], XDATA_H = {{4{x[11]}}, x[11:8]}.
  - 0x10/0x11: Y, same layout. 0x12/0x13: Z, same layout.
  - 0x2D: POWER_CTL.
- Writes:
  - Only 0x2D and 0x1F are writable.
  - 0x2D stores the full byte into power_ctl.
  - 0x1F with value 0x52 clears power_ctl and DATA_READY; any other value is ignored. 0x1F reads 0x00.
  - Writes to all other addresses are ignored.
- DATA_READY:
  - Set by a data_ready pulse.
  - Cleared when address 0x0E or 0x08 is loaded into tx_shift.
  - If set and clear occur in the same cycle, set wins.
- Reset asserted mid-transaction forces all reset values immediately. After reset deasserts with n_CS already low, stay in IDLE until the next cs_fall.

Decomposition:
- Shared package adxl362_pkg:
  - Command constants: CMD_WRITE=8'h0A, CMD_READ=8'h0B.
  - Register address localparams.
  - SOFT_RESET_KEY=8'h52.
  - State encoding for the FSM.
- Sub-module spi_pin_sync: 2-flop synchronizer plus edge detector for a 1-bit pin, outputting level, rise and fall. Instantiated three times.

Test Plan:
- Read IDs: n_CS low, send 0x0B, 0x00, then clock 3 bytes -> MISO returns 0xAD, 0x1D, 0xF2; busy=1 throughout, 0 after n_CS high.
- Burst data read: x=12'h800, y=12'h7FF, z=12'h001; read 0x0B, 0x0E, 6 bytes -> 0x00, 0xF8, 0xFF, 0x07, 0x01, 0x00. Changing the inputs mid-burst has no effect on the returned bytes.
- Write/soft reset: write 0x0A, 0x2D, 0x02 -> power_ctl=0x02; write 0x0A, 0x1F, 0x52 -> power_ctl=0x00; write 0x1F with 0x51 -> no change.
- Status: pulse data_ready, read 0x0B -> 0x01; read 0x0E, then read 0x0B again -> 0x00. A data_ready pulse coincident with the 0x0E load leaves status at 0x01.
- Aborts: raise n_CS after 4 bits of the write data byte -> power_ctl unchanged. Command 0x0D -> MISO stays 0 for 16 clocks.
- Wrap and reset: burst read starting at 0xFF -> 0x00 then 0xAD. Asserting reset mid-burst -> MISO=0, busy=0 within 1 cycle.
